// File: rtl/csa_resolver.sv
// Multi-cycle carry-save resolver: folds a sum/carry vector pair into binary,
// CHUNK bits per cycle through a narrow adder and a 1-bit rippling carry.
module csa_resolver #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] sum_i,
   input  logic [WIDTH-1:0] carry_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] result_o,
   output logic             cout_o
);

   localparam int NCH = WIDTH / CHUNK;
   localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ADD  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [KW-1:0] K_LAST = KW'(NCH - 1);

   logic [1:0]       state_reg;
   logic [1:0]       state_next;
   logic [KW-1:0]    k_reg;
   logic             run_carry_reg;
   logic             cout_reg;
   logic [WIDTH-1:0] sum_lat_reg;
   logic [WIDTH-1:0] carry_lat_reg;

   logic [CHUNK-1:0] sum_chunk     [NCH];
   logic [CHUNK-1:0] carry_chunk   [NCH];
   logic [CHUNK-1:0] res_chunk_reg [NCH];

   logic [CHUNK-1:0] sum_sel;
   logic [CHUNK-1:0] carry_sel;
   logic [CHUNK:0]   chunk_add;

   // Slice the operand latches into chunks; the running carry is the only
   // link between them, so the adder below stays CHUNK+1 bits wide.
   for (genvar gi = 0; gi < NCH; gi++) begin : g_chunk
      assign sum_chunk[gi]   = sum_lat_reg[gi*CHUNK +: CHUNK];
      assign carry_chunk[gi] = carry_lat_reg[gi*CHUNK +: CHUNK];
      assign result_o[gi*CHUNK +: CHUNK] = res_chunk_reg[gi];

      always_ff @(posedge clk_i) begin
         if (!rst_ni) begin
            res_chunk_reg[gi] <= '0;
         end else if (state_reg == ADD && k_reg == KW'(gi)) begin
            res_chunk_reg[gi] <= chunk_add[CHUNK-1:0];
         end
      end
   end

   assign sum_sel   = sum_chunk[k_reg];
   assign carry_sel = carry_chunk[k_reg];
   assign chunk_add = {1'b0, sum_sel} + {1'b0, carry_sel}
                    + {{CHUNK{1'b0}}, run_carry_reg};

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (in_valid_i) state_next = ADD;
         ADD:     if (k_reg == K_LAST) state_next = DONE;
         DONE:    if (out_ready_i) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_reg     <= IDLE;
         k_reg         <= '0;
         run_carry_reg <= 1'b0;
         cout_reg      <= 1'b0;
         sum_lat_reg   <= '0;
         carry_lat_reg <= '0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            IDLE: begin
               if (in_valid_i) begin
                  sum_lat_reg   <= sum_i;
                  carry_lat_reg <= carry_i;
                  k_reg         <= '0;
                  run_carry_reg <= 1'b0;
               end
            end
            ADD: begin
               run_carry_reg <= chunk_add[CHUNK];
               if (k_reg == K_LAST) begin
                  cout_reg <= chunk_add[CHUNK];
                  k_reg    <= '0;
               end else begin
                  k_reg <= k_reg + KW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready_o  = (state_reg == IDLE);
   assign out_valid_o = (state_reg == DONE);
   assign cout_o      = cout_reg;

endmodule

// File: tb/tb_csa_resolver.sv
// Scoreboard bench for csa_resolver: driver queues expected results, a
// negedge monitor checks latency, hold stability and handshake values.
module tb_csa_resolver;

   localparam int WIDTH = 16;
   localparam int CHUNK = 4;
   localparam int NCH   = WIDTH / CHUNK;

   logic             clk_i = 1'b0;
   logic             rst_ni = 1'b0;
   logic             in_valid_i = 1'b0;
   logic             in_ready_o;
   logic [WIDTH-1:0] sum_i = '0;
   logic [WIDTH-1:0] carry_i = '0;
   logic             out_valid_o;
   logic             out_ready_i = 1'b1;
   logic [WIDTH-1:0] result_o;
   logic             cout_o;

   csa_resolver #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .sum_i       (sum_i),
      .carry_i     (carry_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .result_o    (result_o),
      .cout_o      (cout_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [WIDTH-1:0] res;
      logic             cout;
      int unsigned      acc;
   } exp_t;

   exp_t        exp_q[$];
   int          errors = 0;
   int          checks = 0;
   int unsigned cyc = 0;
   int unsigned last_acc = 0;
   logic        prev_valid = 1'b0;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: latency on the rising edge of out_valid, result held every
   // DONE cycle, and the full result/cout compared at the handshake.
   always @(negedge clk_i) begin
      if (out_valid_o) begin
         if (exp_q.size() == 0) begin
            check("unexpected_out_valid", 32'(out_valid_o), 32'd0);
         end else begin
            if (!prev_valid) check("latency", cyc - exp_q[0].acc, NCH);
            check("result", 32'(result_o), 32'(exp_q[0].res));
            if (out_ready_i) begin
               check("cout", 32'(cout_o), 32'(exp_q[0].cout));
               $display("op done: result=0x%04h cout=%0d", result_o, cout_o);
               void'(exp_q.pop_front());
            end
         end
      end
      prev_valid = out_valid_o;
   end

   task automatic issue(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c, input bit push);
      int n = 0;
      while (!in_ready_o && n < 50) begin
         @(posedge clk_i); #1;
         n++;
      end
      if (!in_ready_o) begin
         check("in_ready_timeout", 32'(in_ready_o), 32'd1);
      end else begin
         sum_i      = s;
         carry_i    = c;
         in_valid_i = 1'b1;
         last_acc   = cyc + 1;
         if (push) begin
            exp_t e;
            {e.cout, e.res} = {1'b0, s} + {1'b0, c};
            e.acc = cyc + 1;
            exp_q.push_back(e);
         end
         @(posedge clk_i); #1;
         in_valid_i = 1'b0;
      end
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk_i); #1;
         n++;
      end
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int unsigned prev_acc;
      int n;

      rst_ni = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      check("rst_in_ready", 32'(in_ready_o), 32'd1);
      check("rst_out_valid", 32'(out_valid_o), 32'd0);
      check("rst_result", 32'(result_o), 32'd0);
      check("rst_cout", 32'(cout_o), 32'd0);

      // First accept on the very first edge after release.
      rst_ni = 1'b1;
      issue(16'h00FF, 16'h0001, 1'b1);
      check("first_accept_edge", last_acc, cyc);
      drain();
      issue(16'hFFFF, 16'h0001, 1'b1);
      drain();
      issue(16'h8000, 16'h8000, 1'b1);
      issue(16'h0F0F, 16'h00F1, 1'b1);
      drain();

      // Backpressure with a competing operand presented throughout.
      out_ready_i = 1'b0;
      issue(16'h1234, 16'h4321, 1'b1);
      in_valid_i = 1'b1;
      sum_i      = 16'hAAAA;
      carry_i    = 16'h5555;
      n = 0;
      while (!out_valid_o && n < 20) begin
         @(posedge clk_i); #1;
         n++;
      end
      check("bp_out_valid", 32'(out_valid_o), 32'd1);
      repeat (5) begin
         check("bp_in_ready", 32'(in_ready_o), 32'd0);
         check("bp_hold_valid", 32'(out_valid_o), 32'd1);
         @(posedge clk_i); #1;
      end
      in_valid_i  = 1'b0;
      out_ready_i = 1'b1;
      @(posedge clk_i); #1;
      check("bp_in_ready_after", 32'(in_ready_o), 32'd1);
      check("bp_valid_after", 32'(out_valid_o), 32'd0);
      repeat (8) @(posedge clk_i);
      #1;
      check("bp_no_extra", 32'(exp_q.size()), 32'd0);

      // Reset during the second ADD cycle discards the operation.
      issue(16'hFFFF, 16'hFFFF, 1'b0);
      @(posedge clk_i); #1;
      rst_ni = 1'b0;
      @(posedge clk_i); #1;
      check("abort_out_valid", 32'(out_valid_o), 32'd0);
      check("abort_result", 32'(result_o), 32'd0);
      check("abort_cout", 32'(cout_o), 32'd0);
      check("abort_in_ready", 32'(in_ready_o), 32'd1);
      rst_ni = 1'b1;
      repeat (8) @(posedge clk_i);
      #1;
      check("abort_result_later", 32'(result_o), 32'd0);
      check("abort_in_ready_later", 32'(in_ready_o), 32'd1);

      // Back-to-back stream; accepts must be exactly NCH+2 cycles apart.
      prev_acc = 0;
      for (int i = 0; i < 1000; i++) begin
         issue(WIDTH'($urandom), WIDTH'($urandom), 1'b1);
         if (i > 0) check("accept_spacing", last_acc - prev_acc, NCH + 2);
         prev_acc = last_acc;
      end
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/csa_resolver.md
CSA_RESOLVER -- requirements
Module: csa_resolver

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, giving the width of each carry-save addend and of the result.
REQ-002 The module SHALL have parameter CHUNK, default 4, giving the bits resolved per cycle; WIDTH SHALL be an integer multiple of CHUNK, and NCH = WIDTH/CHUNK.
REQ-003 The module SHALL have port clk_i, input, 1 bit: the single clock.
REQ-004 The module SHALL have port rst_ni, input, 1 bit: reset, synchronous and active-low.
REQ-005 The module SHALL have port in_valid_i, input, 1 bit: input operands valid.
REQ-006 The module SHALL have port in_ready_o, output, 1 bit: the block accepts operands.
REQ-007 The module SHALL have port sum_i, input, WIDTH bits: carry-save sum vector.
REQ-008 The module SHALL have port carry_i, input, WIDTH bits: carry-save carry vector, already bit-aligned with sum_i (no internal shift).
REQ-009 The module SHALL have port out_valid_o, output, 1 bit: result valid.
REQ-010 The module SHALL have port out_ready_i, input, 1 bit: downstream accepts the result.
REQ-011 The module SHALL have port result_o, output, WIDTH bits: resolved binary value (sum_i + carry_i) mod 2^WIDTH.
REQ-012 The module SHALL have port cout_o, output, 1 bit: bit WIDTH of sum_i + carry_i.

Function
REQ-013 The block SHALL implement an FSM with states IDLE, ADD and DONE, all state held in registers.
REQ-014 in_ready_o SHALL be 1 only in IDLE; out_valid_o SHALL be 1 only in DONE; both SHALL be decoded from state only, with no combinational path from any input.
REQ-015 In IDLE, when in_valid_i = 1, the block SHALL latch sum_i and carry_i, clear the chunk index and the running carry to 0, and go to ADD.
REQ-016 In IDLE, when in_valid_i = 0, the block SHALL stay in IDLE with all registers unchanged.
REQ-017 In ADD, each cycle SHALL add latched chunk k of sum and carry plus the running carry, write the CHUNK-bit result to result bits [k*CHUNK +: CHUNK], update the running carry, and increment k.
REQ-018 The running carry register SHALL be 1 bit wide and is the only inter-chunk dependency; there SHALL be no full-width adder in the datapath.
REQ-019 In ADD with k = NCH-1, the block SHALL write the final chunk, load cout_o with the chunk carry-out, and go to DONE.
REQ-020 Latency: out_valid_o SHALL rise exactly NCH cycles after the accept edge (4 cycles at the defaults).
REQ-021 In DONE, result_o and cout_o SHALL hold stable, and in_valid_i SHALL be ignored.
REQ-022 In DONE with out_ready_i = 1, the block SHALL go to IDLE; in_ready_o rises on the following cycle.
REQ-023 Sustained throughput SHALL be one operation per NCH+2 cycles.
REQ-024 result_o and cout_o SHALL keep their last value in IDLE and SHALL update chunk by chunk in ADD; they are valid only when out_valid_o = 1.
REQ-025 in_valid_i asserted in ADD or DONE SHALL have no effect, and the operand latches SHALL not change.
REQ-026 The bit-WIDTH overflow SHALL appear only on cout_o; result_o SHALL wrap modulo 2^WIDTH.

Reset
REQ-027 When rst_ni = 0 at a rising edge of clk_i, state SHALL become IDLE, k = 0, running carry = 0, result_o = 0, cout_o = 0 and operand latches = 0.
REQ-028 After reset, out_valid_o SHALL be 0 and in_ready_o SHALL be 1.
REQ-029 Reset asserted in ADD or DONE SHALL abort the operation with no output handshake, and the discarded result SHALL never appear.
REQ-030 The first accept SHALL be possible in the first cycle after rst_ni returns to 1.

Verification (WIDTH=16, CHUNK=4)
REQ-031 Accept sum 0x00FF, carry 0x0001 -> result_o 0x0100 and cout_o 0, with out_valid_o exactly 4 cycles after accept.
REQ-032 Accept sum 0xFFFF, carry 0x0001 -> result_o 0x0000 and cout_o 1, with the carry rippling through all 4 chunks.
REQ-033 Accept 0x1234 + 0x4321, then hold out_ready_i = 0 for 5 cycles while driving in_valid_i = 1 with 0xAAAA/0x5555 -> result_o stays 0x5555, in_ready_o stays 0, and the second operand is not taken.
REQ-034 Accept 0xFFFF + 0xFFFF and assert rst_ni = 0 in the 2nd ADD cycle -> out_valid_o 0, result_o 0, cout_o 0, in_ready_o 1 after release, and no result handshake occurs.
REQ-035 Drive 1000 random back-to-back operations with out_ready_i = 1 -> every result matches a (sum+carry) reference model, and consecutive accepts are spaced exactly 6 cycles apart.
